// File: rtl/mc_data_split.sv
// Fast-side receiver: captures half-rate words on a fixed pll_clock phase,
// buffers two of them and streams each word out as two half-words.
module mc_data_split #(
    parameter int WIDTH     = 32,
    parameter int INVERT    = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic                 pll_clock,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 valid_in,
    output logic [WIDTH/2-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 overflow,
    input  logic                 clear_overflow,
    output logic                 phase
);

    localparam int   HW        = WIDTH / 2;
    localparam logic CAP_PHASE = INVERT[0];
    localparam logic LSB_FIRST_B = LSB_FIRST[0];

    logic             phase_q;
    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             h_q;
    logic             overflow_q;

    logic             cap;
    logic             push;
    logic             accept;
    logic             pop;
    logic             full;
    logic             push_ok;
    logic             drop;
    logic             sel_upper;
    logic [WIDTH-1:0] head;

    // The launching div_clock register only changes on the other phase,
    // so sampling on this phase alone gives it a two-cycle path.
    assign cap     = (phase_q == CAP_PHASE);
    assign push    = cap & valid_in;
    assign full    = (count_q == 2'd2);
    assign accept  = out_valid & out_ready;
    assign pop     = accept & h_q;
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge pll_clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q    <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            h_q        <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            phase_q <= ~phase_q;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_in;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
            if (accept) begin
                h_q <= ~h_q;
            end
            // A drop on the same edge as a clear keeps the flag set.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clear_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign sel_upper = h_q ^ ~LSB_FIRST_B;
    assign out_data  = sel_upper ? head[WIDTH-1:HW] : head[HW-1:0];
    assign out_valid = (count_q != 2'd0);
    assign out_last  = h_q;
    assign overflow  = overflow_q;
    assign phase     = phase_q;

endmodule

// File: tb/tb_mc_data_split.sv
// Bench for mc_data_split: word-queue reference model feeding a half-word
// scoreboard, with two DUTs covering both half orderings.
module tb_mc_data_split;

    localparam int   W   = 32;
    localparam int   H   = 16;
    localparam logic INV = 1'b1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data_in;
    logic         valid_in;
    logic         out_ready;
    logic         clear_ovf;

    logic [H-1:0] l_data, m_data;
    logic         l_valid, m_valid, l_last, m_last, l_ovf, m_ovf, l_phase, m_phase;

    mc_data_split #(.WIDTH(W), .INVERT(1), .LSB_FIRST(1)) u_l (
        .pll_clock(clk), .reset_n(rst_n), .data_in(data_in), .valid_in(valid_in),
        .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready), .out_last(l_last),
        .overflow(l_ovf), .clear_overflow(clear_ovf), .phase(l_phase));

    mc_data_split #(.WIDTH(W), .INVERT(1), .LSB_FIRST(0)) u_m (
        .pll_clock(clk), .reset_n(rst_n), .data_in(data_in), .valid_in(valid_in),
        .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready), .out_last(m_last),
        .overflow(m_ovf), .clear_overflow(clear_ovf), .phase(m_phase));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq[$];
    logic [H:0]   sbl[$];
    logic [H:0]   sbm[$];
    logic         mh, movf, mphase;
    logic         m_acc, m_pop, m_full, m_push;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a two-deep word queue plus a half index.
    initial begin
        mh = 1'b0; movf = 1'b0; mphase = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete(); sbl.delete(); sbm.delete();
                mh = 1'b0; movf = 1'b0; mphase = 1'b0;
            end else begin
                m_acc  = (mq.size() != 0) && out_ready;
                m_pop  = m_acc && mh;
                m_full = (mq.size() == 2);
                m_push = (mphase == INV) && valid_in;
                if (m_acc) mh = !mh;
                if (m_pop) void'(mq.pop_front());
                if (m_push && (!m_full || m_pop)) begin
                    mq.push_back(data_in);
                    sbl.push_back({1'b0, data_in[H-1:0]});
                    sbl.push_back({1'b1, data_in[W-1:H]});
                    sbm.push_back({1'b0, data_in[W-1:H]});
                    sbm.push_back({1'b1, data_in[H-1:0]});
                end
                if (m_push && m_full && !m_pop) movf = 1'b1;
                else if (clear_ovf)            movf = 1'b0;
                mphase = !mphase;
            end
        end
    end

    // Monitor: compares presented halves against the scoreboard heads.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("phase_l", 32'(l_phase), 32'(mphase));
                chk("phase_m", 32'(m_phase), 32'(mphase));
                chk("valid_l", 32'(l_valid), 32'(mq.size() != 0));
                chk("valid_m", 32'(m_valid), 32'(mq.size() != 0));
                chk("ovf_l", 32'(l_ovf), 32'(movf));
                chk("ovf_m", 32'(m_ovf), 32'(movf));
                if (l_valid) begin
                    if (sbl.size() == 0) begin
                        chk("sb_l_nonempty", 32'(sbl.size()), 32'd1);
                    end else begin
                        chk("data_l", 32'(l_data), 32'(sbl[0][H-1:0]));
                        chk("last_l", 32'(l_last), 32'(sbl[0][H]));
                        if (out_ready) void'(sbl.pop_front());
                    end
                end
                if (m_valid) begin
                    if (sbm.size() == 0) begin
                        chk("sb_m_nonempty", 32'(sbm.size()), 32'd1);
                    end else begin
                        chk("data_m", 32'(m_data), 32'(sbm[0][H-1:0]));
                        chk("last_m", 32'(m_last), 32'(sbm[0][H]));
                        if (out_ready) void'(sbm.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w);
        while (mphase != INV) tick();
        data_in  = w;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        data_in  = $urandom;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (mq.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk(nm, 32'(l_valid | m_valid), 32'd0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, 32'({l_valid, m_valid}), 32'd0);
        chk({nm, "_data"},  32'({l_data, m_data}), 32'd0);
        chk({nm, "_last"},  32'({l_last, m_last}), 32'd0);
        chk({nm, "_ovf"},   32'({l_ovf, m_ovf}), 32'd0);
        chk({nm, "_phase"}, 32'({l_phase, m_phase}), 32'd0);
    endtask

    initial begin
        data_in = '0; valid_in = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
        repeat (3) tick();
        chk_zero("reset");
        rst_n = 1'b1;
        #1;
        chk_zero("post_reset");

        // Single word, both orderings checked through the scoreboards.
        out_ready = 1'b1;
        send(32'hA5A5_1234);
        drain("drain_single");

        // Back-to-back words on every capture edge.
        for (int i = 1; i <= 8; i++) send(W'(i));
        drain("drain_stream");

        // Stall: third word is dropped.
        out_ready = 1'b0;
        send(32'h1111_AAAA);
        send(32'h2222_BBBB);
        send(32'h3333_CCCC);
        tick();
        chk("ovf_set", 32'({l_ovf, m_ovf}), 32'h3);
        drain("drain_stall");
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("ovf_clr", 32'({l_ovf, m_ovf}), 32'h0);

        // Full FIFO: final half accepted on the same edge a new word lands.
        out_ready = 1'b0;
        send(32'h4444_DDDD);
        send(32'h5555_EEEE);
        out_ready = 1'b1;
        valid_in  = 1'b1;
        data_in   = 32'h6666_FFFF;
        tick();
        tick();
        valid_in = 1'b0;
        chk("full_swap_ovf", 32'({l_ovf, m_ovf}), 32'h0);
        chk("full_swap_valid", 32'({l_valid, m_valid}), 32'h3);
        drain("drain_swap");

        // Asynchronous reset after the first half of a word is taken.
        send(32'h7777_0101);
        tick();
        rst_n = 1'b0;
        #1;
        chk_zero("mid_reset");
        #2;
        rst_n    = 1'b1;
        valid_in = 1'b1;
        data_in  = 32'h8888_0202;
        tick();
        chk("phase0_no_cap", 32'({l_valid, m_valid}), 32'h0);
        tick();
        chk("phase1_cap", 32'({l_valid, m_valid}), 32'h3);
        valid_in = 1'b0;
        drain("drain_reset");

        // Randomised traffic with stalls, drops and clears.
        for (int i = 0; i < 800; i++) begin
            data_in   = $urandom;
            valid_in  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            clear_ovf = ($urandom_range(0, 9) == 0);
            tick();
        end
        valid_in  = 1'b0;
        clear_ovf = 1'b0;
        drain("drain_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
